// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//  Shared AES-128 definitions for the iterative decryption core:
//   - byte/word/block typedefs and the control FSM state enum
//   - SBOX / INV_SBOX substitution tables and the RCON table
//   - GF(2^8) helpers (xtime, gmul) using the polynomial x^8+x^4+x^3+x+1
//   - forward and reverse key-schedule steps (one round key per call)
//  Byte 0 of a 128-bit block is bits [127:120]; bytes fill the state column
//  by column (byte i sits at row i%4, column i/4).
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYEXP = 2'd1,
        DEC    = 2'd2,
        DONE   = 2'd3
    } fsm_t;

    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Round constants indexed by round number 1..10; entry 0 and the padding
    // above 10 are never selected by a live round.
    localparam byte_t RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiply; with a constant b this folds to an XOR network.
    function automatic byte_t gmul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic byte_t get_byte(input block_t blk, input int idx);
        return blk[127 - 8*idx -: 8];
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    // k(i) from k(i-1), rcon = RCON[i].
    function automatic block_t key_fwd(input block_t k, input byte_t rcon);
        word_t t;
        word_t n0, n1, n2, n3;
        t  = sub_word(rot_word(k[31:0])) ^ {rcon, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // k(i-1) from k(i), rcon = RCON[i]. w3 is recovered first because the
    // g() term that restores w0 depends on it.
    function automatic block_t key_rev(input block_t k, input byte_t rcon);
        word_t w0, w1, w2, w3;
        w3 = k[31:0]  ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_word(rot_word(w3)) ^ {rcon, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// ---------------------------------------------------------------------------
// aes_inv_round
//  Combinational AES inverse round:
//   next_state = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ round_key)
//  or, with last=1, the same without InvMixColumns (final round).
// Ports
//  state       in   128  current cipher state
//  round_key   in   128  round key added before InvMixColumns
//  last        in   1    bypass InvMixColumns
//  next_state  out  128  resulting state
// ---------------------------------------------------------------------------
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] next_state
);

    logic [127:0] ark;
    logic [127:0] mix;

    // Output byte i (row i%4, col i/4) takes input row r from column (c-r) mod 4.
    function automatic int inv_shift_src(input int i);
        return (i % 4) + 4 * (((i / 4) + 4 - (i % 4)) % 4);
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch can be inferred.
        ark        = '0;
        mix        = '0;
        next_state = '0;

        for (int i = 0; i < 16; i++) begin
            ark[127 - 8*i -: 8] = INV_SBOX[get_byte(state, inv_shift_src(i))] ^ get_byte(round_key, i);
        end

        for (int c = 0; c < 4; c++) begin
            mix[127 - 8*(4*c)     -: 8] = gmul(get_byte(ark, 4*c),   8'h0e) ^ gmul(get_byte(ark, 4*c+1), 8'h0b)
                                        ^ gmul(get_byte(ark, 4*c+2), 8'h0d) ^ gmul(get_byte(ark, 4*c+3), 8'h09);
            mix[127 - 8*(4*c + 1) -: 8] = gmul(get_byte(ark, 4*c),   8'h09) ^ gmul(get_byte(ark, 4*c+1), 8'h0e)
                                        ^ gmul(get_byte(ark, 4*c+2), 8'h0b) ^ gmul(get_byte(ark, 4*c+3), 8'h0d);
            mix[127 - 8*(4*c + 2) -: 8] = gmul(get_byte(ark, 4*c),   8'h0d) ^ gmul(get_byte(ark, 4*c+1), 8'h09)
                                        ^ gmul(get_byte(ark, 4*c+2), 8'h0e) ^ gmul(get_byte(ark, 4*c+3), 8'h0b);
            mix[127 - 8*(4*c + 3) -: 8] = gmul(get_byte(ark, 4*c),   8'h0b) ^ gmul(get_byte(ark, 4*c+1), 8'h0d)
                                        ^ gmul(get_byte(ark, 4*c+2), 8'h09) ^ gmul(get_byte(ark, 4*c+3), 8'h0e);
        end

        next_state = last ? ark : mix;
    end

endmodule

// File: rtl/aes_decrypt_iter.sv
// ---------------------------------------------------------------------------
// aes_decrypt_iter
//  Iterative AES-128 decryption core. A ciphertext/key pair is accepted in
//  IDLE, the key is expanded forward to the last round key (KEYEXP, 10
//  cycles), then ten inverse rounds run one per clock while the round keys
//  are regenerated backwards (DEC). The plaintext is then held in DONE until
//  the consumer takes it.
//
//  Optional feature macro: AES_DEC_KEY_CACHE_EN
//   When defined, the last cipher key and its round-10 key are remembered;
//   a block arriving with the same key skips KEYEXP (10-cycle latency
//   instead of 20).
//
// Parameters
//  NR     number of rounds (10, AES-128 only)
//  CTR_W  round counter width, must hold 0..NR
// Ports
//  clk        in   1    clock, rising edge
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    ct/key valid
//  in_ready   out  1    core can accept (IDLE only)
//  ct         in   128  ciphertext, byte 0 = bits[127:120]
//  key        in   128  cipher key, same byte order
//  out_valid  out  1    pt valid, held until taken
//  out_ready  in   1    consumer accepts pt
//  pt         out  128  plaintext
//  busy       out  1    high during KEYEXP and DEC
// ---------------------------------------------------------------------------
module aes_decrypt_iter
    import aes_pkg::*;
#(
    parameter int NR    = 10,
    parameter int CTR_W = 4
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt,
    output logic         busy
);

    localparam logic [CTR_W-1:0] RC_ONE  = CTR_W'(1);
    localparam logic [CTR_W-1:0] RC_LAST = CTR_W'(NR);

    fsm_t             fsm;
    logic [127:0]     state_q;
    logic [127:0]     key_reg;
    logic [127:0]     ct_reg;
    logic [CTR_W-1:0] rc;
    logic [127:0]     pt_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [127:0]     k_fwd;
    logic [127:0]     k_rev;
    logic [127:0]     round_out;
    logic             accept;

`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0]     key0_reg;     // cipher key of the block in flight
    logic [127:0]     cache_key;
    logic [127:0]     cache_k10;
    logic             cache_vld;
    logic             cache_hit;

    assign cache_hit = cache_vld && (key == cache_key);
`endif

    // in_ready_q is only ever high in IDLE, so this is the accept condition.
    assign accept = in_valid && in_ready_q;

    // One schedule step each way; rc selects the round constant for both.
    assign k_fwd = key_fwd(key_reg, RCON[rc]);
    assign k_rev = key_rev(key_reg, RCON[rc]);

    aes_inv_round u_inv_round (
        .state      (state_q),
        .round_key  (k_rev),
        .last       (rc == RC_ONE),
        .next_state (round_out)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm         <= IDLE;
            state_q     <= '0;
            key_reg     <= '0;
            ct_reg      <= '0;
            rc          <= '0;
            pt_q        <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
            key0_reg    <= '0;
            cache_key   <= '0;
            cache_k10   <= '0;
            cache_vld   <= 1'b0;
`endif
        end else begin
            case (fsm)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
                        key0_reg   <= key;
                        if (cache_hit) begin
                            // Round-10 key already known: start the inverse rounds directly.
                            state_q <= ct ^ cache_k10;
                            key_reg <= cache_k10;
                            rc      <= RC_LAST;
                            fsm     <= DEC;
                        end else begin
                            key_reg <= key;
                            ct_reg  <= ct;
                            rc      <= RC_ONE;
                            fsm     <= KEYEXP;
                        end
`else
                        key_reg    <= key;
                        ct_reg     <= ct;
                        rc         <= RC_ONE;
                        fsm        <= KEYEXP;
`endif
                    end
                end

                KEYEXP: begin
                    key_reg <= k_fwd;
                    if (rc == RC_LAST) begin
                        // Initial AddRoundKey uses k10 straight off the expansion
                        // logic; rc stays at NR to start the reverse schedule.
                        state_q <= ct_reg ^ k_fwd;
                        fsm     <= DEC;
`ifdef AES_DEC_KEY_CACHE_EN
                        cache_key <= key0_reg;
                        cache_k10 <= k_fwd;
                        cache_vld <= 1'b1;
`endif
                    end else begin
                        rc <= rc + RC_ONE;
                    end
                end

                DEC: begin
                    key_reg <= k_rev;
                    state_q <= round_out;
                    rc      <= rc - RC_ONE;
                    if (rc == RC_ONE) begin
                        pt_q        <= round_out;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        fsm         <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        fsm         <= IDLE;
                    end
                end

                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign pt        = pt_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// ---------------------------------------------------------------------------
// tb_aes_decrypt_iter
//  Self-checking bench for aes_decrypt_iter. Each driven block pushes its
//  expected plaintext and latency onto a scoreboard queue; the entry is
//  popped and compared when the core presents out_valid. Covers reset
//  values, FIPS-197 vectors, the internal round-10 key, backpressure, reset
//  in mid-operation and (with AES_DEC_KEY_CACHE_EN) the key-cache shortcut.
// ---------------------------------------------------------------------------
module tb_aes_decrypt_iter;

    localparam logic [127:0] APPB_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] APPB_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] APPB_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] APPB_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] C1_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT    = 128'h00112233445566778899aabbccddeeff;

`ifdef AES_DEC_KEY_CACHE_EN
    localparam int HIT_LAT = 10;
`else
    localparam int HIT_LAT = 20;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] ct = '0;
    logic [127:0] key = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] pt;
    logic         busy;

    typedef struct {
        logic [127:0] pt;
        int           lat;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   acc_cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    aes_decrypt_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ct        (ct),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pt        (pt),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Waits for in_ready, presents one block and returns #1 after the accept edge.
    task automatic send(input logic [127:0] k, input logic [127:0] c,
                        input logic [127:0] exp_pt, input int exp_lat);
        exp_t e;
        int   t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("in_ready_wait", in_ready, 1'b1);
            return;
        end
        key      = k;
        ct       = c;
        in_valid = 1'b1;
        e.pt     = exp_pt;
        e.lat    = exp_lat;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        key      = '0;
        ct       = '0;
    endtask

    // Waits for out_valid, checks against the scoreboard, optionally applies
    // five cycles of backpressure, then completes the handshake.
    task automatic receive(input string tag, input bit hold);
        exp_t e;
        int   t;
        t = 0;
        while (!out_valid && t < 60) begin
            @(posedge clk);
            #1;
            t++;
        end
        check({tag, "_out_valid"}, out_valid, 1'b1);
        if (sb_q.size() == 0 || !out_valid) return;
        e = sb_q.pop_front();
        check({tag, "_latency"}, cyc - acc_cyc, e.lat);
        check({tag, "_pt"}, pt, e.pt);
        if (hold) begin
            repeat (5) begin
                @(posedge clk);
                #1;
                check({tag, "_hold_pt"}, pt, e.pt);
                check({tag, "_hold_valid"}, out_valid, 1'b1);
                check({tag, "_hold_in_ready"}, in_ready, 1'b0);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_after_valid"}, out_valid, 1'b0);
        check({tag, "_after_in_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset values while rst_n is held low.
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_pt", pt, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_in_ready", in_ready, 1'b1);
        check("idle_busy", busy, 1'b0);

        // FIPS-197 App.B, internal round-10 key, then backpressure.
        send(APPB_KEY, APPB_CT, APPB_PT, 20);
        repeat (10) @(posedge clk);
        #1;
        check("appb_k10", dut.key_reg, APPB_K10);
        check("appb_busy", busy, 1'b1);
        check("appb_in_ready_busy", in_ready, 1'b0);
        receive("appb", 1'b1);

        // FIPS-197 C.1 (different key: always the full path).
        send(C1_KEY, C1_CT, C1_PT, 20);
        receive("c1", 1'b0);

        // Reset in the middle of a block: aborted silently.
        send(APPB_KEY, APPB_CT, APPB_PT, 20);
        repeat (14) @(posedge clk);
        #1;
        check("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_in_ready", in_ready, 1'b0);
        if (sb_q.size() > 0) void'(sb_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        check("no_partial_result", out_valid, 1'b0);

        send(C1_KEY, C1_CT, C1_PT, 20);
        receive("c1_after_rst", 1'b0);

        // Same key twice back-to-back, then a new key.
        send(APPB_KEY, APPB_CT, APPB_PT, 20);
        receive("appb_first", 1'b0);
        send(APPB_KEY, APPB_CT, APPB_PT, HIT_LAT);
        receive("appb_second", 1'b0);
        send(C1_KEY, C1_CT, C1_PT, 20);
        receive("c1_new_key", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
